// File: rtl/tdm_demux_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tdm_demux_if : serial word input and published-frame output bundle    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface tdm_demux_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                     in_valid;
    logic                     in_sof;
    logic [WIDTH-1:0]         in_data;
    logic [LANES*WIDTH-1:0]   out_data;
    logic                     out_valid;
    logic                     sync_err;
    logic                     locked;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_data, out_valid, sync_err, locked
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_data, out_valid, sync_err, locked
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tdm_demux : lane TDM receive demux, atomic frame publish, SOF checking |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tdm_demux #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  wire           clk,
    input  wire           rst_n,
    tdm_demux_if.slave    bus
);
    localparam int           LW          = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] c_LANE_ONE  = LW'(1 % LANES);
    localparam logic [LW-1:0] c_LANE_LAST = LW'(LANES - 1);

    typedef enum logic [0:0] {
        S_HUNT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LW-1:0]           r_lane;
    logic [LW-1:0]           w_lane_nxt;
    logic [WIDTH-1:0]        r_stage [LANES];
    logic                    w_wr_en;
    logic [LW-1:0]           w_wr_lane;
    logic                    w_publish;
    logic                    w_sync_err;
    logic [LANES*WIDTH-1:0]  w_frame;
    logic [LANES*WIDTH-1:0]  r_out_data;
    logic                    r_out_valid;
    logic                    r_sync_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HUNT;
            r_lane      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane      <= w_lane_nxt;
            r_out_valid <= w_publish;
            r_sync_err  <= w_sync_err;
            if (w_publish) begin
                r_out_data <= w_frame;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_wr_en     = 1'b0;
        w_wr_lane   = '0;
        w_publish   = 1'b0;
        w_sync_err  = 1'b0;
        if (bus.in_valid) begin
            if (r_state == S_HUNT) begin
                if (bus.in_sof) begin
                    w_wr_en     = 1'b1;
                    w_lane_nxt  = c_LANE_ONE;
                    w_state_nxt = S_RUN;
                    w_publish   = (LANES == 1);
                end
            end else if (r_lane == '0) begin
                if (bus.in_sof) begin
                    w_wr_en    = 1'b1;
                    w_lane_nxt = c_LANE_ONE;
                    w_publish  = (LANES == 1);
                end else begin
                    w_sync_err  = 1'b1;
                    w_lane_nxt  = '0;
                    w_state_nxt = S_HUNT;
                end
            end else if (!bus.in_sof) begin
                w_wr_en    = 1'b1;
                w_wr_lane  = r_lane;
                w_publish  = (r_lane == c_LANE_LAST);
                w_lane_nxt = (r_lane == c_LANE_LAST) ? '0 : r_lane + 1'b1;
            end else begin
                // Early SOF restarts the frame on this word; the partial frame is abandoned.
                w_sync_err = 1'b1;
                w_wr_en    = 1'b1;
                w_lane_nxt = c_LANE_ONE;
            end
        end
    end

    // The final lane is taken straight from the input so the whole frame lands in one update.
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage[k] <= '0;
                end else if (w_wr_en && (w_wr_lane == LW'(k))) begin
                    r_stage[k] <= bus.in_data;
                end
            end
            assign w_frame[k*WIDTH +: WIDTH] = (k == LANES - 1) ? bus.in_data : r_stage[k];
        end
    endgenerate

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.sync_err  = r_sync_err;
    assign bus.locked    = (r_state == S_RUN);
endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_tdm_demux : directed self-checking bench for tdm_demux (8b x 4)    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_tdm_demux;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    tdm_demux_if #(.WIDTH(8), .LANES(4)) bus ();

    tdm_demux #(.WIDTH(8), .LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one cycle of input, then step to just after the edge that consumes it.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic e, input logic l,
                           input logic [31:0] d);
        chk({tag, ".valid"},  {31'b0, bus.out_valid}, {31'b0, v});
        chk({tag, ".err"},    {31'b0, bus.sync_err},  {31'b0, e});
        chk({tag, ".locked"}, {31'b0, bus.locked},    {31'b0, l});
        chk({tag, ".data"},   bus.out_data,           d);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 32'h0);
        rst_n = 1'b1;

        // Back-to-back frame
        step(1, 1, 8'h11); chk_out("f1.w0", 0, 0, 1, 32'h0);
        step(1, 0, 8'h22); chk_out("f1.w1", 0, 0, 1, 32'h0);
        step(1, 0, 8'h33); chk_out("f1.w2", 0, 0, 1, 32'h0);
        step(1, 0, 8'h44); chk_out("f1.pub", 1, 0, 1, 32'h44332211);
        step(0, 0, 8'h00); chk_out("f1.hold", 0, 0, 1, 32'h44332211);

        // Same frame with idle gaps
        step(1, 1, 8'h11); step(0, 0, 8'h00);
        step(1, 0, 8'h22); step(0, 0, 8'h00); step(0, 0, 8'h00);
        step(1, 0, 8'h33); chk_out("gap.w2", 0, 0, 1, 32'h44332211);
        step(0, 0, 8'h00); step(0, 0, 8'h00); step(0, 0, 8'h00);
        chk_out("gap.idle", 0, 0, 1, 32'h44332211);
        step(1, 0, 8'h44); chk_out("gap.pub", 1, 0, 1, 32'h44332211);
        step(0, 0, 8'h00); chk_out("gap.once", 0, 0, 1, 32'h44332211);

        // Reset, then words without SOF are discarded while hunting
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step(1, 0, 8'hAA); chk_out("hunt.aa", 0, 0, 0, 32'h0);
        step(1, 0, 8'hBB); chk_out("hunt.bb", 0, 0, 0, 32'h0);
        step(1, 1, 8'h01); chk_out("hunt.lock", 0, 0, 1, 32'h0);
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        step(1, 0, 8'h04); chk_out("hunt.pub", 1, 0, 1, 32'h04030201);

        // Early SOF mid-frame
        step(1, 1, 8'h10);
        step(1, 0, 8'h20);
        step(1, 1, 8'h55); chk_out("early.err", 0, 1, 1, 32'h04030201);
        step(1, 0, 8'h66); chk_out("early.w1", 0, 0, 1, 32'h04030201);
        step(1, 0, 8'h77);
        step(1, 0, 8'h88); chk_out("early.pub", 1, 0, 1, 32'h88776655);

        // Missing SOF after a complete frame
        step(1, 0, 8'h99); chk_out("miss.err", 0, 1, 0, 32'h88776655);
        step(0, 0, 8'h00); chk_out("miss.idle", 0, 0, 0, 32'h88776655);
        step(1, 1, 8'hA1); chk_out("miss.relock", 0, 0, 1, 32'h88776655);
        step(1, 0, 8'hB2);
        step(1, 0, 8'hC3);
        step(1, 0, 8'hD4); chk_out("miss.pub", 1, 0, 1, 32'hD4C3B2A1);

        // Early SOF on the final lane slot: error, no publish
        step(1, 1, 8'hE1);
        step(1, 0, 8'hE2);
        step(1, 0, 8'hE3);
        step(1, 1, 8'hF0); chk_out("last.err", 0, 1, 1, 32'hD4C3B2A1);
        step(1, 0, 8'hF1);
        step(1, 0, 8'hF2);
        step(1, 0, 8'hF3); chk_out("last.pub", 1, 0, 1, 32'hF3F2F1F0);

        // Asynchronous reset mid-frame
        step(1, 1, 8'h01);
        step(1, 0, 8'h02);
        #2; rst_n = 1'b0; #1;
        chk_out("arst", 0, 0, 0, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step(1, 0, 8'h33); chk_out("arst.hunt", 0, 0, 0, 32'h0);
        step(1, 1, 8'h5A);
        step(1, 0, 8'h6B);
        step(1, 0, 8'h7C);
        step(1, 0, 8'h8D); chk_out("arst.pub", 1, 0, 1, 32'h8D7C6B5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
